// File: rtl/matrix_pkg.sv
// Shared geometry, pixel layout and byte-phase types
// for the double-buffered LED matrix framebuffer.
package matrix_pkg;

  localparam int LENGTH   = 5;
  localparam int SCAN_BIT = 3;
  localparam int BITDEPTH = 8;

  localparam int HALF   = LENGTH * (2 ** SCAN_BIT);
  localparam int DEPTH  = 2 * HALF;
  localparam int ADDR_W = $clog2(HALF);
  localparam int IDX_W  = $clog2(DEPTH);

  typedef struct packed {
    logic [BITDEPTH-1:0] b;
    logic [BITDEPTH-1:0] g;
    logic [BITDEPTH-1:0] r;
  } pixel_t;

  typedef enum logic [1:0] {
    PH_R,
    PH_G,
    PH_B
  } byte_phase_e;

  // Top bitdepth bits of a received byte.
  function automatic logic [BITDEPTH-1:0] chan(
    input logic [7:0] d
  );
    return d[7 -: BITDEPTH];
  endfunction

endpackage

// File: rtl/matrix_framebuffer_if.sv
// Byte stream in, driver read port out.
// master = stream source / scan driver, slave = framebuffer.
interface matrix_framebuffer_if;
  import matrix_pkg::*;

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [ADDR_W-1:0] addr;
  pixel_t            data1;
  pixel_t            data2;
  logic              display_bank;
  logic              frame_done;
  logic              overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output addr,
    input  data1,
    input  data2,
    input  display_bank,
    input  frame_done,
    input  overrun
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  addr,
    output data1,
    output data2,
    output display_bank,
    output frame_done,
    output overrun
  );

endinterface

// File: rtl/matrix_fb_ram.sv
// Two-bank pixel store: one write port,
// two registered read ports sharing a bank select.
module matrix_fb_ram
  import matrix_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic             wr_bank,
  input  logic [IDX_W-1:0] wr_idx,
  input  pixel_t           wr_data,
  input  logic             rd_bank,
  input  logic [IDX_W-1:0] rd_idx1,
  input  logic [IDX_W-1:0] rd_idx2,
  output pixel_t           rd_data1,
  output pixel_t           rd_data2
);

  pixel_t mem [2][DEPTH];

  // Array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[wr_bank][wr_idx] <= wr_data;
  end

  // Registered reads, one cycle after the index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data1 <= '0;
      rd_data2 <= '0;
    end else begin
      rd_data1 <= mem[rd_bank][rd_idx1];
      rd_data2 <= mem[rd_bank][rd_idx2];
    end
  end

endmodule

// File: rtl/matrix_framebuffer.sv
// Packs R,G,B bytes into the hidden bank and swaps
// banks only on a full-frame boundary of the scan.
module matrix_framebuffer
  import matrix_pkg::*;
#(
  parameter int idle_timeout = 4096
) (
  input logic clk,
  input logic reset,
  matrix_framebuffer_if.slave bus
);

  localparam int IDLE_W = $clog2(idle_timeout + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX =
    IDLE_W'(idle_timeout);
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'(HALF - 1);

  byte_phase_e         phase;
  logic [IDX_W-1:0]    wptr;
  logic [BITDEPTH-1:0] red_q;
  logic [BITDEPTH-1:0] grn_q;
  logic                swap_pending;
  logic [IDLE_W-1:0]   idle_cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic                display_bank;

  byte_phase_e      phase_eff;
  logic [IDX_W-1:0] wptr_eff;
  logic [IDX_W-1:0] rd_idx1;
  logic [IDX_W-1:0] rd_idx2;
  logic             timeout;
  logic             accept;
  logic             we;
  logic             last_px;
  logic             boundary;
  logic             swap;
  logic             rd_bank;
  pixel_t           wr_px;

  // Resync, write strobe, boundary and read-bank select.
  always_comb begin
    timeout   = (idle_cnt == IDLE_MAX) &&
                (phase != PH_R || wptr != '0);
    phase_eff = timeout ? PH_R : phase;
    wptr_eff  = timeout ? '0 : wptr;
    accept    = bus.rx_valid && !swap_pending;
    we        = accept && (phase_eff == PH_B);
    last_px   = (wptr_eff == LAST_IDX);
    boundary  = (bus.addr == '0) &&
                (addr_q == LAST_ADDR);
    swap      = boundary && swap_pending;
    rd_bank   = swap ? ~display_bank : display_bank;
    rd_idx1   = IDX_W'(bus.addr);
    rd_idx2   = IDX_W'(bus.addr) + IDX_W'(HALF);
    wr_px.r   = red_q;
    wr_px.g   = grn_q;
    wr_px.b   = chan(bus.rx_data);
  end

  // Byte assembly, write pointer, idle resync and bank swap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase          <= PH_R;
      wptr           <= '0;
      red_q          <= '0;
      grn_q          <= '0;
      swap_pending   <= 1'b0;
      idle_cnt       <= '0;
      addr_q         <= '0;
      display_bank   <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      addr_q         <= bus.addr;
      bus.frame_done <= we && last_px;
      bus.overrun    <= bus.rx_valid && swap_pending;

      if (bus.rx_valid)
        idle_cnt <= '0;
      else if (idle_cnt != IDLE_MAX)
        idle_cnt <= idle_cnt + 1'b1;

      phase <= phase_eff;
      wptr  <= wptr_eff;
      if (accept) begin
        unique case (phase_eff)
          PH_R: begin
            red_q <= chan(bus.rx_data);
            phase <= PH_G;
          end
          PH_G: begin
            grn_q <= chan(bus.rx_data);
            phase <= PH_B;
          end
          PH_B: begin
            phase <= PH_R;
            wptr  <= last_px ? '0 : wptr_eff + 1'b1;
          end
          default: phase <= PH_R;
        endcase
      end

      if (swap) begin
        display_bank <= ~display_bank;
        swap_pending <= 1'b0;
      end else if (we && last_px) begin
        swap_pending <= 1'b1;
      end
    end
  end

  assign bus.display_bank = display_bank;

  matrix_fb_ram u_ram (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .wr_bank  (~display_bank),
    .wr_idx   (wptr_eff),
    .wr_data  (wr_px),
    .rd_bank  (rd_bank),
    .rd_idx1  (rd_idx1),
    .rd_idx2  (rd_idx2),
    .rd_data1 (bus.data1),
    .rd_data2 (bus.data2)
  );

endmodule

// File: tb/tb_matrix_framebuffer.sv
// Bench for matrix_framebuffer: directed frames, table
// reads and random traffic against a frame-level model.
module tb_matrix_framebuffer;
  import matrix_pkg::*;

  localparam int IDLE   = 4096;
  localparam int FBYTES = 3 * DEPTH;

  logic clk = 1'b0;
  logic reset;

  matrix_framebuffer_if bus();

  matrix_framebuffer #(.idle_timeout(IDLE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time exceeded limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          addr;
    logic [23:0] d1;
    logic [23:0] d2;
  } rd_vec_t;

  rd_vec_t tbl [6];

  int n_tests = 0;
  int n_fail  = 0;
  int fd_seen = 0;
  int ov_seen = 0;

  // Frame-level reference model.
  logic [23:0] mref [2][DEPTH];
  logic [7:0]  m_buf [3];
  int          m_cnt;
  int          m_idle;
  int          m_prev;
  bit          m_pend;
  bit          m_bank;
  logic [23:0] exp_d1;
  logic [23:0] exp_d2;
  bit          exp_fd;
  bit          exp_ov;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h @%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_idle = 0;
    m_prev = 0;
    m_pend = 0;
    m_bank = 0;
    exp_d1 = '0;
    exp_d2 = '0;
    exp_fd = 0;
    exp_ov = 0;
  endtask

  // One clock edge of the framebuffer's visible rules.
  task automatic model_edge(input bit v,
                            input logic [7:0] b,
                            input int a);
    bit old_pend;
    bit bnd;
    old_pend = m_pend;
    bnd = (a == 0) && (m_prev == HALF - 1);
    exp_fd = 0;
    exp_ov = 0;
    if (v) begin
      if (old_pend) begin
        exp_ov = 1;
      end else begin
        if (m_idle >= IDLE) m_cnt = 0;
        m_buf[m_cnt % 3] = b;
        m_cnt++;
        if (m_cnt % 3 == 0)
          mref[!m_bank][m_cnt / 3 - 1] =
            {m_buf[2], m_buf[1], m_buf[0]};
        if (m_cnt == FBYTES) begin
          exp_fd = 1;
          m_cnt  = 0;
        end
      end
      m_idle = 0;
    end else begin
      m_idle++;
    end
    if (bnd && old_pend) begin
      m_bank = !m_bank;
      m_pend = 0;
    end
    if (exp_fd) m_pend = 1;
    m_prev = a;
    exp_d1 = mref[m_bank][a];
    exp_d2 = mref[m_bank][a + HALF];
  endtask

  task automatic step(input bit v,
                      input logic [7:0] b,
                      input int a);
    bus.rx_valid = v;
    bus.rx_data  = b;
    bus.addr     = ADDR_W'(a);
    @(posedge clk);
    model_edge(v, b, a);
    #1;
    bus.rx_valid = 1'b0;
    if (bus.frame_done === 1'b1) fd_seen++;
    if (bus.overrun === 1'b1) ov_seen++;
    chk("data1", 64'(bus.data1), 64'(exp_d1));
    chk("data2", 64'(bus.data2), 64'(exp_d2));
    chk("display_bank", 64'(bus.display_bank),
        64'(m_bank));
    chk("frame_done", 64'(bus.frame_done),
        64'(exp_fd));
    chk("overrun", 64'(bus.overrun), 64'(exp_ov));
  endtask

  task automatic boundary();
    step(0, 8'h00, HALF - 1);
    step(0, 8'h00, 0);
  endtask

  task automatic sweep();
    for (int a = 0; a < HALF; a++) step(0, 8'h00, a);
  endtask

  task automatic rand_bytes(input int n);
    for (int i = 0; i < n; i++)
      step(1, 8'($urandom), 5);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_data1"}, 64'(bus.data1), 64'd0);
    chk({tag, "_data2"}, 64'(bus.data2), 64'd0);
    chk({tag, "_bank"}, 64'(bus.display_bank), 64'd0);
    chk({tag, "_fd"}, 64'(bus.frame_done), 64'd0);
    chk({tag, "_ov"}, 64'(bus.overrun), 64'd0);
  endtask

  initial begin
    int fd0;
    int ov0;
    bit bk;
    int sc;

    tbl[0] = '{3,  24'h050403, 24'h2d2c2b};
    tbl[1] = '{0,  24'h020100, 24'h2a2928};
    tbl[2] = '{17, 24'h131211, 24'h3b3a39};
    tbl[3] = '{39, 24'h292827, 24'h51504f};
    tbl[4] = '{20, 24'h161514, 24'h3e3d3c};
    tbl[5] = '{1,  24'h030201, 24'h2b2a29};

    for (int k = 0; k < 2; k++)
      for (int i = 0; i < DEPTH; i++)
        mref[k][i] = '0;
    model_reset();

    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    bus.addr     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    #2 reset = 1'b0;

    // Idle sweep after reset: zeros, no pulses.
    sweep();
    chk("t1_pulses", 64'(fd_seen + ov_seen), 64'd0);

    // Known frame, then swap at the scan boundary.
    fd0 = fd_seen;
    for (int p = 0; p < DEPTH; p++) begin
      step(1, 8'(p), 5);
      step(1, 8'(p + 1), 5);
      step(1, 8'(p + 2), 5);
    end
    chk("t2_frame_done", 64'(bus.frame_done), 64'd1);
    chk("t2_fd_count", 64'(fd_seen - fd0), 64'd1);
    step(0, 8'h00, HALF - 1);
    chk("t2_bank_before", 64'(bus.display_bank), 64'd0);
    step(0, 8'h00, 0);
    chk("t2_bank_after", 64'(bus.display_bank), 64'd1);
    for (int i = 0; i < 6; i++) begin
      step(0, 8'h00, tbl[i].addr);
      chk("t2_tbl_data1", 64'(bus.data1), 64'(tbl[i].d1));
      chk("t2_tbl_data2", 64'(bus.data2), 64'(tbl[i].d2));
    end

    // Full frame with no boundary, then extra bytes.
    rand_bytes(FBYTES);
    ov0 = ov_seen;
    bk  = bus.display_bank;
    rand_bytes(3);
    chk("t3_overrun", 64'(ov_seen - ov0), 64'd3);
    chk("t3_bank_held", 64'(bus.display_bank), 64'(bk));
    boundary();
    chk("t3_bank_swap", 64'(bus.display_bank), 64'(!bk));
    sweep();
    rand_bytes(FBYTES);
    boundary();
    sweep();

    // Partial frame abandoned by idle timeout.
    fd0 = fd_seen;
    rand_bytes(100);
    repeat (IDLE) step(0, 8'h00, 5);
    for (int i = 0; i < FBYTES; i++) step(1, 8'hAA, 5);
    chk("t4_fd_count", 64'(fd_seen - fd0), 64'd1);
    boundary();
    for (int a = 0; a < HALF; a++) begin
      step(0, 8'h00, a);
      chk("t4_data1", 64'(bus.data1), 64'hAAAAAA);
      chk("t4_data2", 64'(bus.data2), 64'hAAAAAA);
    end

    // Asynchronous reset mid-frame.
    fd0 = fd_seen;
    rand_bytes(7);
    #2 reset = 1'b1;
    #1;
    chk_reset_vals("t5");
    model_reset();
    #1 reset = 1'b0;
    rand_bytes(FBYTES);
    chk("t5_fd_count", 64'(fd_seen - fd0), 64'd1);
    boundary();
    chk("t5_bank", 64'(bus.display_bank), 64'd1);
    sweep();

    // Frame completion on the boundary edge itself.
    rand_bytes(FBYTES - 1);
    step(0, 8'h00, HALF - 1);
    bk = bus.display_bank;
    step(1, 8'($urandom), 0);
    chk("t6_frame_done", 64'(bus.frame_done), 64'd1);
    chk("t6_bank_held", 64'(bus.display_bank), 64'(bk));
    for (int a = 1; a < HALF; a++) step(0, 8'h00, a);
    chk("t6_bank_still", 64'(bus.display_bank), 64'(bk));
    step(0, 8'h00, 0);
    chk("t6_bank_swap", 64'(bus.display_bank), 64'(!bk));

    // Random traffic against the model.
    sc = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1000) begin
        for (int j = 0; j < IDLE + 4; j++) begin
          sc = (sc + 1) % HALF;
          step(0, 8'h00, sc);
        end
      end
      if ($urandom_range(0, 49) == 0)
        sc = $urandom_range(0, HALF - 1);
      else
        sc = (sc + 1) % HALF;
      step($urandom_range(0, 2) != 0, 8'($urandom), sc);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_framebuffer.md
Name: matrix_framebuffer

Overview:
- Double-buffered pixel store directly upstream of the LED matrix scan driver.
- Accepts the UART receiver byte stream (R,G,B per pixel, row-major, top half then bottom half) and packs it into 24-bit pixels.
- Writes pixels into the hidden bank. Serves the driver's addr with one-cycle-latency data1 (top half) and data2 (bottom half) from the displayed bank.
- Swaps banks only at a full-frame boundary of the driver's scan, so no tearing.

Parameters:
- length, 5: panel columns per scan row.
- scan_bit, 3: select width; 2**scan_bit rows per half.
- bitdepth, 8: bits per colour channel. Must be ≤ 8.
- idle_timeout, 4096: clk cycles without rx_valid before the write pointer resynchronises.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid; no backpressure
- addr  in  $clog2(HALF)  driver read address, HALF = length*2**scan_bit
- data1  out  3*bitdepth  pixel at addr, top half; [bitdepth-1:0]=red, then green, then blue
- data2  out  3*bitdepth  pixel at addr+HALF, bottom half; same packing
- display_bank  out  1  bank currently read by the driver
- frame_done  out  1  one-cycle pulse when the last byte of a frame is written
- overrun  out  1  one-cycle pulse when a byte is dropped

Behaviour:
- Reset values (async):
  - data1/data2 = 0; display_bank = 0.
  - frame_done = overrun = 0.
  - byte phase = 0; write pointer = 0.
  - swap_pending = 0; idle counter = 0.
- Byte assembly: phase 0→1→2 (R,G,B).
  - Channel value = rx_data[7 -: bitdepth].
  - R and G are held in a pixel register.
  - On B, the pixel is written next edge to RAM[~display_bank][wptr], and wptr increments.
- Write pointer range is 0..2*HALF-1.
  - Writing index 2*HALF-1 pulses frame_done, sets swap_pending, and resets wptr and phase to 0.
- While swap_pending = 1:
  - Every rx_valid byte is discarded and pulses overrun.
  - Phase and wptr do not move.
- Idle timeout:
  - The counter clears on rx_valid and increments otherwise, saturating.
  - When it reaches idle_timeout with phase ≠ 0 or wptr ≠ 0, phase and wptr reset to 0. The partial frame is abandoned; no swap and no pulse.
  - The counter's match takes effect in that cycle. If rx_valid arrives in the same cycle, the byte is treated as phase 0 of a fresh frame.
- Frame boundary detection:
  - addr_q is a registered copy of addr, reset value 0.
  - Boundary = addr == 0 && addr_q == HALF-1.
- Swap: on a boundary with swap_pending = 1, display_bank toggles and swap_pending clears.
  - The read launched in that cycle already uses the new bank.
  - If frame completion and a boundary coincide, the swap waits for the next boundary.
- Read path: data1/data2 are registered; they reflect addr one clk after addr is presented.
  - This matches the driver's one-cycle delay on its PWM compare.
- Hazards:
  - The write port never targets display_bank, so there is no read/write collision.
  - addr values ≥ HALF are out of contract; data for them is don't-care.
- Reset mid-frame discards all progress. RAM contents are not cleared.

Decomposition:
- Package matrix_pkg:
  - Localparams HALF and ADDR_W derived from length/scan_bit.
  - Typedef pixel_t (3*bitdepth packed struct r/g/b).
  - Typedef byte_phase_e {PH_R, PH_G, PH_B}.
- Sub-module matrix_fb_ram:
  - Two banks × 2*HALF × pixel_t.
  - One write port (bank, index, data, we).
  - Two registered read ports (bank, index), single clock, no reset on the array.

Test Plan:
- Reset, no input, sweep addr 0..39 → data1/data2 = 0 one cycle later; display_bank = 0; no pulses.
- Send 240 bytes (pixel i = {R=i, G=i+1, B=i+2}); let the driver sweep addr 39→0 → frame_done pulses after byte 240, display_bank = 1 at the boundary. Then addr = 3 → data1 = {B=5,G=4,R=3}; data2 (pixel 43) = {B=45,G=44,R=43}.
- Full frame sent, no boundary yet, then 3 extra bytes → three overrun pulses, display_bank unchanged, wptr still 0. After the boundary swap, a new frame writes into bank 0.
- Send 100 bytes, idle 4096 cycles, then 240 bytes of 0xAA → exactly one frame_done; all pixels read 0xAAAAAA after the swap.
- Assert reset for 1 cycle mid-frame (byte 7) → outputs return to reset values immediately (async); the next 240 bytes form a complete frame.
- Frame completion and boundary in the same cycle → display_bank toggles only at the following boundary (HALF scan later).
